relocador_desvio: RTL

//  Per-process branch-target relocation unit. It replaces fixed-block branch correction with a writable base/limit table.

---
 rtl/relocador_desvio.sv | 96 +++++++++
 1 files changed

// File: rtl/relocador_desvio.sv
// Per-process branch-target relocation with base/limit table and sticky fault stats.
// Latency 1 cycle; response held until resp_ready, req_ready = !resp_valid | resp_ready.
module relocador_desvio #(
  parameter int ADDR_W    = 11,
  parameter int PROC_W    = 3,
  parameter int TAM_BLOCO = 300,
  parameter int CNT_W     = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tab_we,
  input  logic [PROC_W-1:0] tab_proc,
  input  logic [ADDR_W-1:0] tab_base,
  input  logic [ADDR_W-1:0] tab_limite,
  input  logic              modo_sistema,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] desvio_in,
  input  logic [PROC_W-1:0] processo,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] desvio_out,
  output logic              falha,
  output logic              falha_sticky,
  input  logic              falha_clr,
  output logic [CNT_W-1:0]  cnt_falhas
);
  localparam int N_PROC = 2 ** PROC_W;

  logic [ADDR_W-1:0] base_tab [N_PROC];
  logic [ADDR_W-1:0] lim_tab  [N_PROC];

  logic              accept;
  logic              lim_fail;
  logic [ADDR_W:0]   soma;
  logic              falha_nxt;
  logic [ADDR_W-1:0] desvio_nxt;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  // Table reads here see the pre-write entry, so a same-cycle write never affects the accepted request.
  always_comb begin
    lim_fail   = desvio_in >= lim_tab[processo];
    soma       = {1'b0, base_tab[processo]} + {1'b0, desvio_in};
    falha_nxt  = 1'b0;
    desvio_nxt = desvio_in;
    if (!modo_sistema) begin
      falha_nxt  = lim_fail || soma[ADDR_W];
      desvio_nxt = falha_nxt ? '0 : soma[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PROC; i++) begin
        base_tab[i] <= ADDR_W'(i * TAM_BLOCO);
        lim_tab[i]  <= ADDR_W'(TAM_BLOCO);
      end
    end else if (tab_we) begin
      base_tab[tab_proc] <= tab_base;
      lim_tab[tab_proc]  <= tab_limite;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      desvio_out <= '0;
      falha      <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      desvio_out <= desvio_nxt;
      falha      <= falha_nxt;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Clear has priority over a coinciding fault load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      falha_sticky <= 1'b0;
      cnt_falhas   <= '0;
    end else if (falha_clr) begin
      falha_sticky <= 1'b0;
      cnt_falhas   <= '0;
    end else if (accept && falha_nxt) begin
      falha_sticky <= 1'b1;
      if (cnt_falhas != '1) begin
        cnt_falhas <= cnt_falhas + 1'b1;
      end
    end
  end

endmodule
